// File: rtl/clk_div_ctrl.sv
// Ratio-change sequencer and two-way arbiter for the integer clock divider.
// Optional CLK_DIV_CTRL_RR_EN selects round-robin arbitration (default: req0 priority).
module clk_div_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  RESET_RATIO   = 8'd1
) (
  input  logic       I_ref_clk,
  input  logic       I_rst_n,
  input  logic       I_req0,
  input  logic [7:0] I_ratio0,
  input  logic       I_req1,
  input  logic [7:0] I_ratio1,
  output logic       o_ack0,
  output logic       o_ack1,
  output logic       o_clk_en,
  output logic [7:0] o_div_ratio,
  output logic       o_busy,
  output logic       o_grant_id
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_DRAIN  = 3'd1;
  localparam logic [2:0] ST_LOAD   = 3'd2;
  localparam logic [2:0] ST_SETTLE = 3'd3;
  localparam logic [2:0] ST_ACK    = 3'd4;

  localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);

  logic [2:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ratio_q, ratio_d;
  logic [7:0] div_ratio_q, div_ratio_d;
  logic       clk_en_q, clk_en_d;
  logic       ack0_q, ack0_d;
  logic       ack1_q, ack1_d;
  logic       busy_q, busy_d;
  logic       grant_q, grant_d;
  logic       win;
  logic [7:0] win_ratio;

`ifdef CLK_DIV_CTRL_RR_EN
  logic last_q, last_d;

  // On a tie the requester not granted last time wins
  assign win = (I_req0 && I_req1) ? ~last_q : I_req1;
`else
  assign win = ~I_req0;
`endif

  assign win_ratio = win ? I_ratio1 : I_ratio0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ratio_d     = ratio_q;
    div_ratio_d = div_ratio_q;
    clk_en_d    = clk_en_q;
    grant_d     = grant_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
`ifdef CLK_DIV_CTRL_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (I_req0 || I_req1) begin
          grant_d = win;
          ratio_d = win_ratio;
`ifdef CLK_DIV_CTRL_RR_EN
          last_d  = win;
`endif
          if (win_ratio == div_ratio_q && clk_en_q) begin
            state_d = ST_ACK;
            ack0_d  = ~win;
            ack1_d  = win;
          end else begin
            // Drain long enough for any in-flight divided half-period to finish
            state_d  = ST_DRAIN;
            clk_en_d = 1'b0;
            cnt_d    = (div_ratio_q == 8'd0) ? 8'd1 : div_ratio_q;
          end
        end
      end
      ST_DRAIN: begin
        clk_en_d = 1'b0;
        if (cnt_q == 8'd1) begin
          state_d = ST_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_LOAD: begin
        div_ratio_d = ratio_q;
        cnt_d       = SETTLE_LD;
        state_d     = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q <= 8'd1) begin
          state_d  = ST_ACK;
          clk_en_d = 1'b1;
          ack0_d   = ~grant_q;
          ack1_d   = grant_q;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ACK: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 8'd0;
      ratio_q     <= RESET_RATIO;
      div_ratio_q <= RESET_RATIO;
      clk_en_q    <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ratio_q     <= ratio_d;
      div_ratio_q <= div_ratio_d;
      clk_en_q    <= clk_en_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
      grant_q     <= grant_d;
    end
  end

`ifdef CLK_DIV_CTRL_RR_EN
  always_ff @(posedge I_ref_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  assign o_ack0      = ack0_q;
  assign o_ack1      = ack1_q;
  assign o_clk_en    = clk_en_q;
  assign o_div_ratio = div_ratio_q;
  assign o_busy      = busy_q;
  assign o_grant_id  = grant_q;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: scoreboard of expected grants, checked at each ack.
module tb_clk_div_ctrl;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 1'b0;
  logic       req1 = 1'b0;
  logic [7:0] ratio0 = 8'd0;
  logic [7:0] ratio1 = 8'd0;
  logic       ack0, ack1, clk_en, busy, grant;
  logic [7:0] div_ratio;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       id;
    logic [7:0] ratio;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] m_ratio = 8'd1;
  logic       m_en = 1'b0;
  logic       m_last = 1'b1;

  always #5 clk = ~clk;

  clk_div_ctrl #(.SETTLE_CYCLES(S), .RESET_RATIO(8'd1)) dut (
    .I_ref_clk  (clk),
    .I_rst_n    (rst_n),
    .I_req0     (req0),
    .I_ratio0   (ratio0),
    .I_req1     (req1),
    .I_ratio1   (ratio1),
    .o_ack0     (ack0),
    .o_ack1     (ack1),
    .o_clk_en   (clk_en),
    .o_div_ratio(div_ratio),
    .o_busy     (busy),
    .o_grant_id (grant)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic drop_req(input logic id);
    if (id) req1 = 1'b0;
    else    req0 = 1'b0;
  endtask

  task automatic raise_one(input logic id, input logic [7:0] r);
    exp_t e;
    if (id) begin req1 = 1'b1; ratio1 = r; end
    else    begin req0 = 1'b1; ratio0 = r; end
    e.id = id; e.ratio = r;
    sb_q.push_back(e);
    m_last = id;
  endtask

  task automatic raise_both(input logic [7:0] r0, input logic [7:0] r1);
    exp_t e;
    logic w;
`ifdef CLK_DIV_CTRL_RR_EN
    w = ~m_last;
`else
    w = 1'b0;
`endif
    req0 = 1'b1; ratio0 = r0;
    req1 = 1'b1; ratio1 = r1;
    e.id = w;  e.ratio = w ? r1 : r0;
    sb_q.push_back(e);
    e.id = ~w; e.ratio = w ? r0 : r1;
    sb_q.push_back(e);
    m_last = ~w;
  endtask

  // Called during cycle 0 (controller in IDLE with the request already visible).
  task automatic serve(input bit drop_in_settle);
    exp_t       e;
    int         r, lat, cyc;
    bit         fast, seen, en_bad, dropped;
    logic [7:0] old;
    e = sb_q.pop_front();
    old  = m_ratio;
    r    = (m_ratio == 8'd0) ? 1 : int'(m_ratio);
    fast = (e.ratio == m_ratio) && m_en;
    lat  = fast ? 1 : r + S + 2;
    cyc = 0; seen = 0; en_bad = 0; dropped = 0;
    while (!seen && cyc < 400) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        seen = 1;
      end else begin
        if (cyc >= 1 && clk_en !== 1'(fast)) en_bad = 1;
        if (!fast && cyc == r + 1) chk("ratio_before_load", 32'(div_ratio), 32'(old));
        if (!fast && cyc == r + 2) chk("ratio_after_load", 32'(div_ratio), 32'(e.ratio));
        if (!fast && cyc >= 1) chk("busy_in_seq", 32'(busy), 32'd1);
        if (drop_in_settle && !fast && cyc == r + 2) begin
          drop_req(e.id);
          dropped = 1;
        end
        cyc++;
      end
    end
    chk("ack_latency", 32'(cyc), 32'(lat));
    chk("ack_id", {30'd0, ack1, ack0}, e.id ? 32'd2 : 32'd1);
    chk("grant_id", 32'(grant), 32'(e.id));
    chk("clk_en_at_ack", 32'(clk_en), 32'd1);
    chk("ratio_at_ack", 32'(div_ratio), 32'(e.ratio));
    chk("clk_en_gating", 32'(en_bad), 32'd0);
    $display("txn id=%0d ratio=%0d latency=%0d fast=%0d", e.id, e.ratio, cyc, fast);
    m_ratio = e.ratio;
    m_en    = 1'b1;
    @(posedge clk);
    if (!dropped) drop_req(e.id);
    #1;
    chk("ack_single_cycle", {30'd0, ack1, ack0}, 32'd0);
    chk("busy_idle_after_ack", 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_clk_en"}, 32'(clk_en), 32'd0);
    chk({tag, "_ratio"}, 32'(div_ratio), 32'd1);
    chk({tag, "_acks"}, {30'd0, ack1, ack0}, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant"}, 32'(grant), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs("reset");
    @(posedge clk); #1;

    // Bring-up from reset: R=1, ack at cycle 5
    raise_one(1'b0, 8'd4);  serve(0);
    // 4 -> 6 from requester 1: ack at cycle 8
    raise_one(1'b1, 8'd6);  serve(0);
    // Two tie rounds, each request held until acked
    raise_both(8'd2, 8'd3); serve(0); serve(0);
    raise_both(8'd2, 8'd3); serve(0); serve(0);
    raise_one(1'b1, 8'd6);  serve(0);
    // Fast path: ratio already active and divider enabled
    raise_one(1'b0, 8'd6);  serve(0);
    // Tie right after a req0 grant separates round-robin from fixed priority
    raise_both(8'd2, 8'd3); serve(0); serve(0);

    // Reset pulse during DRAIN
    req1 = 1'b1; ratio1 = 8'd9;
    repeat (2) @(negedge clk);
    chk("drain_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    req1 = 1'b0;
    @(posedge clk); #1;
    chk("no_ack_in_reset", {30'd0, ack1, ack0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_ratio = 8'd1; m_en = 1'b0; m_last = 1'b1;
    @(posedge clk); #1;
    chk("no_ack_after_reset", {30'd0, ack1, ack0}, 32'd0);
    raise_one(1'b1, 8'd7);  serve(0);

    // Ratio 0 with the request withdrawn during SETTLE
    raise_one(1'b0, 8'd0);  serve(1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_retrigger_busy", 32'(busy), 32'd0);
    end
    chk("ratio_zero_applied", 32'(div_ratio), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_div_ctrl.md
# clk_div_ctrl

Sequencing and arbitration controller for the integer clock divider. It owns the divider's enable and ratio inputs and arbitrates ratio-change requests from two requesters, for example the UART TX and RX prescale configuration paths. Every ratio change uses a glitch-safe sequence: gate the divider, drain, load the new ratio, settle, then re-enable. It runs entirely in the `I_ref_clk` domain, between the register file and the divider.

## Interface
- `SETTLE_CYCLES`, default 2: cycles held in SETTLE after loading a ratio (legal 1..15).
- `RESET_RATIO`, default 8'd1: `o_div_ratio` value after reset.
- `I_ref_clk` input, 1: reference clock, all logic on its rising edge.
- `I_rst_n` input, 1: asynchronous, active-low reset.
- `I_req0` input, 1: level request from requester 0.
- `I_ratio0` input, 8: requested ratio from requester 0; must stay stable while `I_req0` is high.
- `I_req1` input, 1: level request from requester 1.
- `I_ratio1` input, 8: requested ratio from requester 1; must stay stable while `I_req1` is high.
- `o_ack0` output, 1: one-cycle pulse when requester 0's ratio is active.
- `o_ack1` output, 1: one-cycle pulse when requester 1's ratio is active.
- `o_clk_en` output, 1: drives the divider clock-enable input.
- `o_div_ratio` output, 8: drives the divider ratio input.
- `o_busy` output, 1: high in every state except IDLE.
- `o_grant_id` output, 1: requester owning the current or most recent sequence.

## Operation
- All outputs are registered.
- Reset values:
  - `o_clk_en`=0, so the divider bypasses the reference clock.
  - `o_div_ratio`=`RESET_RATIO`.
  - `o_ack0`=`o_ack1`=0, `o_busy`=0, `o_grant_id`=0.
  - State IDLE, round-robin pointer "last=1".
- State IDLE:
  - If any request is high, arbitrate, latch the winner's ratio into `ratio_q`, set `o_grant_id`.
  - Fast path: if `ratio_q` equals `o_div_ratio` and `o_clk_en`=1, go to ACK.
  - Otherwise go to DRAIN and load the drain counter with max(`o_div_ratio`,1).
- DRAIN:
  - `o_clk_en`=0.
  - Decrement the counter each cycle; after the loaded number of cycles, go to LOAD.
  - This guarantees any in-flight divided half-period completes.
- LOAD: `o_div_ratio`<=`ratio_q`, for one cycle; go to SETTLE.
- SETTLE: hold for `SETTLE_CYCLES` cycles with `o_clk_en` still 0; go to ACK.
- ACK:
  - `o_clk_en`=1.
  - Pulse the ack line selected by `o_grant_id` for exactly one cycle.
  - Return to IDLE.
- Arbitration with both requests high: see Configuration. The losing request stays pending and is sampled in the next IDLE cycle.
- Requester handshake:
  - The requester deasserts its req on the edge where it sees its ack.
  - The controller samples requests only in IDLE, so a req dropped on time never retriggers.
- Ratio 0 or 1 is legal and passed through unchanged; the divider treats it as bypass.
- Req dropped mid-sequence: the latched `ratio_q` is still applied and the ack still pulses.
- Reset asserted mid-sequence: all state returns to reset values at once, no ack is issued, and requesters must re-request.

## Timing
- Let cycle 0 be the IDLE sampling edge, R = max(old `o_div_ratio`, 1), and S = `SETTLE_CYCLES`.
- Full path:
  - `o_clk_en` is low from cycle 1.
  - DRAIN occupies cycles 1..R.
  - LOAD is cycle R+1, and new `o_div_ratio` is visible from cycle R+2.
  - SETTLE occupies cycles R+2..R+S+1.
  - ACK is cycle R+S+2, with `o_clk_en`=1 and ack=1 in that same cycle.
- Fast path: ack in cycle 1; `o_clk_en` never drops.
- Minimum spacing between two grants is one IDLE cycle after ACK.
- `o_div_ratio` changes only while `o_clk_en`=0.

## Configuration
- `CLK_DIV_CTRL_RR_EN` defined: round-robin arbitration.
  - The requester not granted last wins a tie.
  - The pointer updates at grant.
  - The reset pointer makes req0 win the first tie.
- `CLK_DIV_CTRL_RR_EN` undefined: fixed priority, req0 always wins a tie, and the pointer logic is removed.

## Test plan
- Reset then req0=1 with ratio0=8'd4:
  - `o_clk_en` stays 0.
  - `o_div_ratio`=4 visible at cycle 3.
  - `o_ack0` plus `o_clk_en`=1 at cycle 5, since R=1 and S=2.
- Current ratio 4, req1 with ratio1=8'd6:
  - `o_clk_en` low for cycles 1..7.
  - `o_ack1` at cycle 8.
  - Divider output settles to divide-by-6 with no runt pulse.
- Fast path: current ratio 6 with `o_clk_en`=1, req0 with ratio0=6 → `o_ack0` at cycle 1, `o_clk_en` never drops.
- Simultaneous req0 and req1, ratios 2 and 3, each held until acked:
  - With `CLK_DIV_CTRL_RR_EN`: two back-to-back tie rounds alternate grants, 0 then 1, then 0 then 1.
  - Without it: req0 wins every tie.
- Reset pulse during DRAIN → all outputs at reset values next cycle, no ack, and a re-request completes normally.
- req0 dropped during SETTLE with ratio0=8'd0 → `o_div_ratio`=0 is applied, `o_ack0` still pulses, and the divider bypasses.
